reaction_ctrl: RTL and testbench

Top-level sequencer for the reaction-time game. It arms the pseudo-random delay unit and lights the stimulus LED when the delay expires. It then times the player's response in 4-digit BCD milliseconds and commits valid results to the scoring unit. It sits between the button and tick inputs and the delay/scoring datapath, and drives their load, enable, update and clear strobes.

---
 rtl/reaction_ctrl_if.sv | 26 ++
 rtl/reaction_ctrl.sv | 159 +++++++++++++++
 tb/tb_reaction_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_ctrl_if.sv
// Handshake bundle between the reaction-game sequencer and its button, tick, delay and scoring
// neighbours. The master side drives the inputs; the slave side is the sequencer.
interface reaction_ctrl_if;
  logic        start;
  logic        react;
  logic        clr_best;
  logic        tick_1ms;
  logic        dly_done;
  logic        dly_ld;
  logic        dly_en;
  logic        led;
  logic        sc_update;
  logic        sc_clr;
  logic [15:0] result;
  logic [2:0]  state;

  modport master (
    output start, react, clr_best, tick_1ms, dly_done,
    input  dly_ld, dly_en, led, sc_update, sc_clr, result, state
  );

  modport slave (
    input  start, react, clr_best, tick_1ms, dly_done,
    output dly_ld, dly_en, led, sc_update, sc_clr, result, state
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: arms the random delay, lights the stimulus LED, times the
// response in 4-digit BCD milliseconds and commits valid results to the scoring unit.
module reaction_ctrl #(
  parameter logic [15:0] SAT_BCD    = 16'h9999,
  parameter logic [15:0] CHEAT_CODE = 16'hEEEE
) (
  input logic            clk,
  input logic            reset,
  reaction_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StWait    = 3'd2,
    StTiming  = 3'd3,
    StDone    = 3'd4,
    StCheat   = 3'd5,
    StTimeout = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic        start_q, react_q, clr_q;
  logic        start_edge, react_edge, clr_edge;
  logic [15:0] timer_q, timer_d, timer_inc;
  logic [15:0] result_q, result_d;
  logic        led_q, led_d;
  logic        dly_ld_q, dly_ld_d;
  logic        sc_update_q, sc_update_d;
  logic        sc_clr_q, sc_clr_d;
  logic        dly_en;
  logic        clr_allowed;

  // Ripple-carry BCD increment; any digit at 9 (or illegal) wraps to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_edge = bus.start & ~start_q;
  assign react_edge = bus.react & ~react_q;
  assign clr_edge   = bus.clr_best & ~clr_q;
  assign timer_inc  = bcd_inc(timer_q);

  assign clr_allowed = (state_q == StIdle) || (state_q == StDone) ||
                       (state_q == StCheat) || (state_q == StTimeout);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    result_d    = result_q;
    led_d       = 1'b0;
    dly_ld_d    = 1'b0;
    sc_update_d = 1'b0;
    sc_clr_d    = clr_edge & clr_allowed;
    dly_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        dly_en = 1'b1;
        if (start_edge) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        timer_d = 16'h0000;
        state_d = StWait;
      end
      StWait: begin
        dly_en = bus.tick_1ms;
        if (react_edge) begin
          state_d  = StCheat;
          result_d = CHEAT_CODE;
        end else if (bus.dly_done) begin
          state_d = StTiming;
          led_d   = 1'b1;
        end
      end
      StTiming: begin
        led_d = 1'b1;
        if (react_edge) begin
          // A tick in the same cycle as the response is deliberately dropped.
          state_d     = StDone;
          result_d    = timer_q;
          sc_update_d = 1'b1;
          led_d       = 1'b0;
        end else if (bus.tick_1ms && (timer_q != SAT_BCD)) begin
          timer_d = timer_inc;
          if (timer_inc == SAT_BCD) begin
            state_d  = StTimeout;
            result_d = SAT_BCD;
            led_d    = 1'b0;
          end
        end
      end
      StDone, StCheat, StTimeout: begin
        dly_en = 1'b1;
        if (start_edge) begin
          state_d = StLoad;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StLoad) begin
      dly_ld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b1;
      react_q     <= 1'b1;
      clr_q       <= 1'b0;
      timer_q     <= 16'h0000;
      result_q    <= 16'h0000;
      led_q       <= 1'b0;
      dly_ld_q    <= 1'b0;
      sc_update_q <= 1'b0;
      sc_clr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      react_q     <= bus.react;
      clr_q       <= bus.clr_best;
      timer_q     <= timer_d;
      result_q    <= result_d;
      led_q       <= led_d;
      dly_ld_q    <= dly_ld_d;
      sc_update_q <= sc_update_d;
      sc_clr_q    <= sc_clr_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.result    = result_q;
  assign bus.led       = led_q;
  assign bus.dly_ld    = dly_ld_q;
  assign bus.dly_en    = dly_en;
  assign bus.sc_update = sc_update_q;
  assign bus.sc_clr    = sc_clr_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: trial-level reference model feeds a scoreboard queue, a negedge
// monitor pops and compares whenever a trial ends.
module tb_reaction_ctrl;
  localparam logic [15:0] SatBcd    = 16'h9999;
  localparam logic [15:0] CheatCode = 16'hEEEE;
  localparam logic [2:0]  SIdle = 3'd0, SLoad = 3'd1, SWait = 3'd2, STiming = 3'd3;
  localparam logic [2:0]  SDone = 3'd4, SCheat = 3'd5, STimeout = 3'd6;

  logic clk = 1'b0;
  logic reset;

  reaction_ctrl_if bus ();

  reaction_ctrl #(
    .SAT_BCD   (SatBcd),
    .CHEAT_CODE(CheatCode)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] res;
    logic        upd;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   violations = 0;
  bit   mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Decimal milliseconds to 4-digit BCD.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1ms = 1'b1;
      step();
      bus.tick_1ms = 1'b0;
      if ($urandom_range(1, 0) == 1) step();
    end
  endtask

  task automatic start_trial(input bit clr);
    bus.start    = 1'b1;
    bus.clr_best = clr;
    step();
    bus.start    = 1'b0;
    bus.clr_best = 1'b0;
    check("load_state", bus.state, SLoad);
    check("load_dly_ld", bus.dly_ld, 1);
    if (clr) check("sc_clr_with_start", bus.sc_clr, 1);
    step();
    check("wait_state", bus.state, SWait);
    check("wait_dly_ld_off", bus.dly_ld, 0);
    bus.tick_1ms = 1'b1;
    #1 check("wait_dly_en_tick", bus.dly_en, 1);
    bus.tick_1ms = 1'b0;
    #1 check("wait_dly_en_idle", bus.dly_en, 0);
  endtask

  // Trial with k counted ticks in TIMING; k >= 9999 means never react.
  task automatic trial_timed(input int wait_ticks, input int k, input bit coincide, input bit clr);
    exp_t e;
    start_trial(clr);
    tick_n(wait_ticks);
    bus.dly_done = 1'b1;
    check("led_before_done", bus.led, 0);
    step();
    bus.dly_done = 1'b0;
    check("led_after_done", bus.led, 1);
    check("timing_state", bus.state, STiming);
    check("timing_dly_en", bus.dly_en, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    check("start_ignored_timing", bus.state, STiming);
    if (k >= 9999) begin
      e.st = STimeout; e.res = SatBcd; e.upd = 1'b0;
      exp_q.push_back(e);
      tick_n(9999);
    end else begin
      tick_n(k);
      e.st = SDone; e.res = to_bcd(k); e.upd = 1'b1;
      exp_q.push_back(e);
      bus.react    = 1'b1;
      bus.tick_1ms = coincide;
      step();
      bus.react    = 1'b0;
      bus.tick_1ms = 1'b0;
    end
    step(2);
  endtask

  task automatic trial_cheat(input int wait_ticks, input bit with_done);
    exp_t e;
    start_trial(1'b0);
    tick_n(wait_ticks);
    e.st = SCheat; e.res = CheatCode; e.upd = 1'b0;
    exp_q.push_back(e);
    bus.react    = 1'b1;
    bus.dly_done = with_done;
    step();
    bus.react    = 1'b0;
    bus.dly_done = 1'b0;
    check("cheat_led", bus.led, 0);
    step(2);
  endtask

  // Monitor: pop an expectation at each trial end; track invariants every cycle.
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    bit   entry;
    if (mon_en) begin
      entry = (bus.state != prev_state) &&
              (bus.state == SDone || bus.state == SCheat || bus.state == STimeout);
      if (entry) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_end: state %0d result %h with no trial outstanding",
                   bus.state, bus.result);
        end else begin
          e = exp_q.pop_front();
          check("end_state", bus.state, e.st);
          check("end_result", bus.result, e.res);
          check("end_sc_update", bus.sc_update, e.upd);
        end
      end
      if (bus.sc_update && !(entry && bus.state == SDone)) violations++;
      if (bus.led != (bus.state == STiming)) violations++;
      prev_state = bus.state;
    end
  end

  initial begin
    bus.start    = 1'b1;
    bus.react    = 1'b1;
    bus.clr_best = 1'b0;
    bus.tick_1ms = 1'b0;
    bus.dly_done = 1'b0;
    reset        = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    check("rst_state", bus.state, SIdle);
    check("rst_result", bus.result, 16'h0000);
    check("rst_led", bus.led, 0);
    check("rst_dly_ld", bus.dly_ld, 0);
    check("rst_sc_update", bus.sc_update, 0);
    check("rst_sc_clr", bus.sc_clr, 0);
    check("idle_dly_en", bus.dly_en, 1);
    mon_en    = 1'b1;
    bus.start = 1'b0;
    bus.react = 1'b0;
    step();
    check("idle_after_release", bus.state, SIdle);

    trial_timed(1200, 347, 1'b0, 1'b0);
    trial_cheat(5, 1'b0);
    trial_cheat(3, 1'b1);
    trial_timed(2, 100, 1'b0, 1'b1);
    trial_timed(1, 346, 1'b1, 1'b0);
    trial_timed(1, 999, 1'b1, 1'b0);
    trial_timed(1, 9999, 1'b0, 1'b0);
    check("timeout_hold", bus.result, SatBcd);

    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(2, 0) == 0) begin
        trial_cheat($urandom_range(6, 0), 1'($urandom_range(1, 0)));
      end else begin
        trial_timed($urandom_range(6, 0), $urandom_range(1200, 0), 1'($urandom_range(1, 0)),
                    ($urandom_range(3, 0) == 0));
      end
    end

    // Abort a trial at 0150 with reset, then clear the best score from IDLE.
    start_trial(1'b0);
    bus.dly_done = 1'b1;
    step();
    bus.dly_done = 1'b0;
    tick_n(150);
    check("pre_reset_state", bus.state, STiming);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midreset_state", bus.state, SIdle);
    check("midreset_led", bus.led, 0);
    check("midreset_result", bus.result, 16'h0000);
    step();
    check("sc_clr_before", bus.sc_clr, 0);
    bus.clr_best = 1'b1;
    step();
    bus.clr_best = 1'b0;
    check("sc_clr_pulse", bus.sc_clr, 1);
    check("clr_stays_idle", bus.state, SIdle);
    step();
    check("sc_clr_single", bus.sc_clr, 0);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("invariant_violations", violations, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
